mmio_bus_arbiter: RTL

Shares the processor's single data-memory/I-O bus between two requesters: port 0, the CPU load/store stage, and port 1, a debug/DMA loader. It arbitrates round-robin and sequences each transaction through a small FSM. It decodes the address into the data-memory region or the memory-mapped peripheral registers (HEX, LEDR, LEDG, KEY, SW), and it owns the output registers and input synchronizers for the board I/O.

---
 rtl/mmio_pkg.sv | 37 +++
 rtl/mmio_sync.sv | 29 ++
 rtl/mmio_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus arbiter: peripheral register map,
// FSM state encoding, address-region encoding and address-match helpers.
package mmio_pkg;

    localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

    // Byte-offset bits are ignored when matching a peripheral register.
    localparam logic [31:0] IO_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DWAIT  = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REG_DMEM = 2'd0,
        REG_IO   = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    function automatic logic io_hit(input logic [31:0] addr, input logic [31:0] base);
        return (addr & IO_MASK) == (base & IO_MASK);
    endfunction

    function automatic logic is_io_addr(input logic [31:0] addr);
        return io_hit(addr, ADDR_HEX)  || io_hit(addr, ADDR_LEDR) ||
               io_hit(addr, ADDR_LEDG) || io_hit(addr, ADDR_KEY)  ||
               io_hit(addr, ADDR_SW);
    endfunction

endpackage

// File: rtl/mmio_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous board inputs.
// Both stages load RESET_VAL while reset is asserted.
module mmio_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the raw pin value into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    assign dout = sync_r;

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory / MMIO bus between the CPU
// (port 0) and a debug/DMA loader (port 1). Each transaction runs through
// IDLE -> ACCESS -> (DWAIT) -> RESP; the block also owns the HEX/LEDR/LEDG
// output registers and the SW/KEY synchronizers.
// Optional feature macro: MMIO_KEY_EDGE_EN (sticky key-press flags on KEY reads).
module mmio_bus_arbiter
    import mmio_pkg::*;
#(
    parameter int DBITS             = 32,
    parameter int DMEMADDRBITS      = 13,
    parameter int DMEMWORDBITS      = 2,
    parameter int DMEM_READ_LATENCY = 1
) (
    input  logic                                 CLOCK_50,
    input  logic                                 FPGA_RESET_N,
    input  logic                                 r0_req,
    input  logic                                 r0_we,
    input  logic [DBITS-1:0]                     r0_addr,
    input  logic [DBITS-1:0]                     r0_wdata,
    output logic                                 r0_ack,
    output logic [DBITS-1:0]                     r0_rdata,
    input  logic                                 r1_req,
    input  logic                                 r1_we,
    input  logic [DBITS-1:0]                     r1_addr,
    input  logic [DBITS-1:0]                     r1_wdata,
    output logic                                 r1_ack,
    output logic [DBITS-1:0]                     r1_rdata,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] dmem_addr,
    output logic                                 dmem_we,
    output logic [DBITS-1:0]                     dmem_wdata,
    input  logic [DBITS-1:0]                     dmem_rdata,
    input  logic [9:0]                           sw_in,
    input  logic [3:0]                           key_in,
    output logic [15:0]                          hex_out,
    output logic [9:0]                           ledr_out,
    output logic [7:0]                           ledg_out
);

    localparam logic [1:0]       LAT_M1 = 2'(DMEM_READ_LATENCY - 1);
    localparam logic [DBITS-1:0] ZERO_W = {DBITS{1'b0}};

    state_e           state_r;
    state_e           next_state_s;
    logic             last_grant_r;
    logic             sel_r;
    logic             we_r;
    logic [DBITS-1:0] addr_r;
    logic [15:0]      wdata_r;
    region_e          region_r;
    logic [1:0]       wait_cnt_r;
    logic [DBITS-1:0] data_r;

    logic             any_req_s;
    logic             grant_s;
    logic             req_we_s;
    logic [DBITS-1:0] req_addr_s;
    logic [DBITS-1:0] req_wdata_s;
    region_e          req_region_s;
    logic [DBITS-1:0] io_rdata_s;

    logic [9:0]       sw_sync_s;
    logic [3:0]       key_sync_s;
    logic [3:0]       key_value_s;

    mmio_sync #(.WIDTH(10), .RESET_VAL(10'h3FF)) u_sw_sync (
        .clk   (CLOCK_50),
        .rst_n (FPGA_RESET_N),
        .din   (sw_in),
        .dout  (sw_sync_s)
    );

    mmio_sync #(.WIDTH(4), .RESET_VAL(4'hF)) u_key_sync (
        .clk   (CLOCK_50),
        .rst_n (FPGA_RESET_N),
        .din   (key_in),
        .dout  (key_sync_s)
    );

`ifdef MMIO_KEY_EDGE_EN
    logic [3:0] key_prev_r;
    logic [3:0] key_flags_r;
    logic [3:0] key_fall_s;
    logic       key_rd_s;

    assign key_fall_s = key_prev_r & ~key_sync_s;
    assign key_rd_s   = (state_r == ACCESS) && (region_r == REG_IO) && !we_r &&
                        io_hit(addr_r, ADDR_KEY);

    // Sticky press flags: clear on a KEY read, but a same-cycle new edge survives
    always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            key_prev_r  <= 4'hF;
            key_flags_r <= 4'h0;
        end else begin
            key_prev_r <= key_sync_s;
            if (key_rd_s) begin
                key_flags_r <= key_fall_s;
            end else begin
                key_flags_r <= key_flags_r | key_fall_s;
            end
        end
    end

    assign key_value_s = key_flags_r;
`else
    assign key_value_s = key_sync_s;
`endif

    // Arbitration: a lone request wins at once, a tie goes to the port not granted last
    always_comb begin
        any_req_s = r0_req | r1_req;
        grant_s   = 1'b0;
        if (r0_req && r1_req) begin
            grant_s = ~last_grant_r;
        end else if (r1_req) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            req_we_s    = r1_we;
            req_addr_s  = r1_addr;
            req_wdata_s = r1_wdata;
        end else begin
            req_we_s    = r0_we;
            req_addr_s  = r0_addr;
            req_wdata_s = r0_wdata;
        end
        if (req_addr_s[DBITS-1:DMEMADDRBITS] == {(DBITS-DMEMADDRBITS){1'b0}}) begin
            req_region_s = REG_DMEM;
        end else if (is_io_addr(req_addr_s)) begin
            req_region_s = REG_IO;
        end else begin
            req_region_s = REG_NONE;
        end
    end

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; only a DMEM read detours through DWAIT
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                if ((region_r == REG_DMEM) && !we_r) begin
                    next_state_s = DWAIT;
                end else begin
                    next_state_s = RESP;
                end
            end
            DWAIT: begin
                if (wait_cnt_r == 2'd0) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = DWAIT;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Peripheral read mux, zero-extended to the bus width
    always_comb begin
        io_rdata_s = ZERO_W;
        if (io_hit(addr_r, ADDR_HEX)) begin
            io_rdata_s = {{(DBITS-16){1'b0}}, hex_out};
        end else if (io_hit(addr_r, ADDR_LEDR)) begin
            io_rdata_s = {{(DBITS-10){1'b0}}, ledr_out};
        end else if (io_hit(addr_r, ADDR_LEDG)) begin
            io_rdata_s = {{(DBITS-8){1'b0}}, ledg_out};
        end else if (io_hit(addr_r, ADDR_KEY)) begin
            io_rdata_s = {{(DBITS-4){1'b0}}, key_value_s};
        end else if (io_hit(addr_r, ADDR_SW)) begin
            io_rdata_s = {{(DBITS-10){1'b0}}, sw_sync_s};
        end else begin
            io_rdata_s = ZERO_W;
        end
    end

    // Registered datapath: latch winner, drive memory, update peripherals, respond
    always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            last_grant_r <= 1'b1;
            sel_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= ZERO_W;
            wdata_r      <= 16'h0000;
            region_r     <= REG_NONE;
            wait_cnt_r   <= 2'd0;
            data_r       <= ZERO_W;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            r0_rdata     <= ZERO_W;
            r1_rdata     <= ZERO_W;
            dmem_addr    <= {(DMEMADDRBITS-DMEMWORDBITS){1'b0}};
            dmem_we      <= 1'b0;
            dmem_wdata   <= ZERO_W;
            hex_out      <= 16'h0000;
            ledr_out     <= 10'h000;
            ledg_out     <= 8'h00;
        end else begin
            dmem_we <= 1'b0;
            r0_ack  <= 1'b0;
            r1_ack  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        sel_r    <= grant_s;
                        we_r     <= req_we_s;
                        addr_r   <= req_addr_s;
                        wdata_r  <= req_wdata_s[15:0];
                        region_r <= req_region_s;
                        data_r   <= ZERO_W;
                        // Memory strobes are registered here so they are stable for the ACCESS cycle
                        if (req_region_s == REG_DMEM) begin
                            dmem_addr  <= req_addr_s[DMEMADDRBITS-1:DMEMWORDBITS];
                            dmem_wdata <= req_wdata_s;
                            dmem_we    <= req_we_s;
                        end
                    end
                end
                ACCESS: begin
                    wait_cnt_r <= LAT_M1;
                    if (region_r == REG_IO) begin
                        if (we_r) begin
                            if (io_hit(addr_r, ADDR_HEX)) begin
                                hex_out <= wdata_r;
                            end else if (io_hit(addr_r, ADDR_LEDR)) begin
                                ledr_out <= wdata_r[9:0];
                            end else if (io_hit(addr_r, ADDR_LEDG)) begin
                                ledg_out <= wdata_r[7:0];
                            end
                        end else begin
                            data_r <= io_rdata_s;
                        end
                    end
                end
                DWAIT: begin
                    if (wait_cnt_r == 2'd0) begin
                        data_r <= dmem_rdata;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 2'd1;
                    end
                end
                RESP: begin
                    last_grant_r <= sel_r;
                    if (sel_r) begin
                        r1_ack   <= 1'b1;
                        r1_rdata <= data_r;
                    end else begin
                        r0_ack   <= 1'b1;
                        r0_rdata <= data_r;
                    end
                end
                default: begin
                    wait_cnt_r <= 2'd0;
                end
            endcase
        end
    end

endmodule
